// File: rtl/ofmap_pkg.sv
// Shared types and defaults for the ofmap deskew buffer.
package ofmap_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PE_SIZE = 14;
    localparam int ROW_W       = DEF_PE_SIZE * DEF_DATA_W;
    localparam int TILE_ADDR_W = $clog2(DEF_PE_SIZE);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Width helper that never returns zero, so 1-deep counters stay legal.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofmap_skew_delay.sv
// Per-lane shift line carrying {valid, row, bank} from lane 0 to a skewed lane.
module ofmap_skew_delay
    import ofmap_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] d_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign d_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ofmap_deskew_buffer.sv
// Deskews systolic-array output rows into two ping-pong tile banks and drains them to SRAM.
// Optional: define OFMAP_RELU_EN to clamp negative drained elements to zero.
module ofmap_deskew_buffer
    import ofmap_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PE_SIZE    = 14,
    parameter int NUM_TILES  = 64,
    parameter int MEM_ADDR_W = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [PE_SIZE*DATA_W-1:0]   in_row_i,
    input  logic                        mode_transpose_i,
    output logic [PE_SIZE*DATA_W-1:0]   mem_d_o,
    output logic [MEM_ADDR_W-1:0]       mem_addr_o,
    output logic                        mem_ce_o,
    output logic                        mem_we_o,
    output logic                        finish_o,
    output logic                        err_o
);

    localparam int RW = PE_SIZE * DATA_W;
    localparam int AW = clog2_min1(PE_SIZE);
    localparam int TW = clog2_min1(NUM_TILES);
    localparam int PW = AW + 2;

    if ((64'd1 << MEM_ADDR_W) < 64'(NUM_TILES * PE_SIZE)) begin : g_addr_chk
        $error("MEM_ADDR_W too small to hold NUM_TILES*PE_SIZE words");
    end

    typedef logic [PE_SIZE-1:0][PE_SIZE-1:0][DATA_W-1:0] tile_t;

    logic [AW-1:0]             row_cnt_q, row_cnt_d;
    logic                      wr_sel_q, wr_sel_d;
    logic                      accept;
    logic [PE_SIZE-1:0][PW-1:0] lane_pl;
    logic [1:0]                tile_t_dummy;
    tile_t                     bank_q [2];
    logic [1:0]                full_q, full_d, full_eff, set_full, free_bank;
    drain_state_e              state_q, state_d;
    logic [AW-1:0]             k_q, k_d;
    logic                      rd_sel_q, rd_sel_d, mode_q, mode_d;
    logic [TW-1:0]             tile_cnt_q, tile_cnt_d;
    logic                      err_q;
    logic [RW-1:0]             mem_d_q, mem_d_d;
    logic [MEM_ADDR_W-1:0]     addr_q, addr_d;
    logic                      fin_q, fin_d;

    assign tile_t_dummy = '0;

    assign in_ready_o = !full_q[wr_sel_q] && !(state_q == DRAIN && rd_sel_q == wr_sel_q);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        row_cnt_d = row_cnt_q;
        wr_sel_d  = wr_sel_q;
        if (accept) begin
            if (row_cnt_q == AW'(PE_SIZE-1)) begin
                row_cnt_d = '0;
                wr_sel_d  = ~wr_sel_q;
            end else begin
                row_cnt_d = row_cnt_q + AW'(1);
            end
        end
    end

    // Payload layout {valid, row, bank}; lane i sees lane 0's strobe i cycles later.
    assign lane_pl[0] = {accept, row_cnt_q, wr_sel_q};

    for (genvar i = 1; i < PE_SIZE; i++) begin : g_lane
        ofmap_skew_delay #(.WIDTH(PW), .DEPTH(i)) u_dly (
            .clk (clk),
            .rst (rst),
            .d_i (lane_pl[0]),
            .d_o (lane_pl[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else begin
            for (int i = 0; i < PE_SIZE; i++) begin
                if (lane_pl[i][PW-1])
                    bank_q[lane_pl[i][0]][lane_pl[i][PW-2:1]][i] <= in_row_i[(PE_SIZE-1-i)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        set_full = '0;
        if (lane_pl[PE_SIZE-1][PW-1] && lane_pl[PE_SIZE-1][PW-2:1] == AW'(PE_SIZE-1))
            set_full[lane_pl[PE_SIZE-1][0]] = 1'b1;
    end

    assign full_eff = full_q | set_full;
    assign full_d   = full_eff & ~free_bank;

    // Launch on the filling edge itself: every word is read only after its last element landed.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rd_sel_d   = rd_sel_q;
        mode_d     = mode_q;
        tile_cnt_d = tile_cnt_q;
        free_bank  = '0;
        case (state_q)
            IDLE: begin
                if (full_eff[rd_sel_q]) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    mode_d  = mode_transpose_i;
                end
            end
            DRAIN: begin
                if (k_q == AW'(PE_SIZE-1)) begin
                    free_bank[rd_sel_q] = 1'b1;
                    rd_sel_d   = ~rd_sel_q;
                    k_d        = '0;
                    tile_cnt_d = (tile_cnt_q == TW'(NUM_TILES-1)) ? '0 : tile_cnt_q + TW'(1);
                    if (full_eff[~rd_sel_q]) mode_d = mode_transpose_i;
                    else                     state_d = IDLE;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    function automatic logic [RW-1:0] read_word(input tile_t t, input logic [AW-1:0] k, input logic tr);
        logic [RW-1:0]     w;
        logic [DATA_W-1:0] e;
        w = '0;
        for (int j = 0; j < PE_SIZE; j++) begin
            e = tr ? t[j][k] : t[k][j];
`ifdef OFMAP_RELU_EN
            if (e[DATA_W-1]) e = '0;
`endif
            w[(PE_SIZE-1-j)*DATA_W +: DATA_W] = e;
        end
        return w;
    endfunction

    always_comb begin
        mem_d_d = '0;
        addr_d  = '0;
        fin_d   = 1'b0;
        if (state_d == DRAIN) begin
            mem_d_d = read_word(bank_q[rd_sel_d], k_d, mode_d);
            addr_d  = MEM_ADDR_W'(BASE_ADDR + int'(tile_cnt_d) * PE_SIZE + int'(k_d));
            fin_d   = (k_d == AW'(PE_SIZE-1)) && (tile_cnt_d == TW'(NUM_TILES-1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q  <= '0;
            wr_sel_q   <= 1'b0;
            full_q     <= '0;
            state_q    <= IDLE;
            k_q        <= '0;
            rd_sel_q   <= 1'b0;
            mode_q     <= 1'b0;
            tile_cnt_q <= '0;
            err_q      <= 1'b0;
            mem_d_q    <= '0;
            addr_q     <= '0;
            fin_q      <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            wr_sel_q   <= wr_sel_d;
            full_q     <= full_d;
            state_q    <= state_d;
            k_q        <= k_d;
            rd_sel_q   <= rd_sel_d;
            mode_q     <= mode_d;
            tile_cnt_q <= tile_cnt_d;
            err_q      <= err_q | (in_valid_i & ~in_ready_o);
            mem_d_q    <= mem_d_d;
            addr_q     <= addr_d;
            fin_q      <= fin_d;
        end
    end

    assign mem_d_o    = mem_d_q;
    assign mem_addr_o = addr_q;
    assign mem_ce_o   = (state_q == DRAIN);
    assign mem_we_o   = (state_q == DRAIN);
    assign finish_o   = fin_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ofmap_deskew_buffer.sv
// Bench for ofmap_deskew_buffer: skewed random rows, tile-level reference model, write scoreboard.
module tb_ofmap_deskew_buffer;

    localparam int P = 4, W = 8, NT = 3, BA = 16, MAW = 10, RW = P * W, MAXC = 2048;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [RW-1:0]   in_row_i = '0;
    logic            mode_transpose_i = 1'b0;
    logic [RW-1:0]   mem_d_o;
    logic [MAW-1:0]  mem_addr_o;
    logic            mem_ce_o, mem_we_o, finish_o, err_o;

    ofmap_deskew_buffer #(
        .DATA_W(W), .PE_SIZE(P), .NUM_TILES(NT), .MEM_ADDR_W(MAW), .BASE_ADDR(BA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_row_i         (in_row_i),
        .mode_transpose_i (mode_transpose_i),
        .mem_d_o          (mem_d_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ce_o         (mem_ce_o),
        .mem_we_o         (mem_we_o),
        .finish_o         (finish_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0]  d;
        logic [MAW-1:0] a;
        logic           f;
    } wr_t;

    wr_t           exp_q[$];
    logic [W-1:0]  pres [MAXC][P];
    logic [W-1:0]  nrow [P];
    logic [W-1:0]  cur  [P][P];
    logic [RW-1:0] first_d;
    int            cur_rows, tidx, cyc, n_chk, n_pass, first_ce, n_acc, c0;
    bit            dropped, mode, first_seen;

    function automatic logic [W-1:0] relu(input logic [W-1:0] e);
`ifdef OFMAP_RELU_EN
        return e[W-1] ? '0 : e;
`else
        return e;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // A completed tile becomes PE_SIZE expected writes in drain order.
    task automatic accept_row();
        logic [RW-1:0] w;
        for (int i = 0; i < P; i++) cur[cur_rows][i] = nrow[i];
        cur_rows++;
        n_acc++;
        if (cur_rows == P) begin
            for (int k = 0; k < P; k++) begin
                w = '0;
                for (int j = 0; j < P; j++)
                    w[(P-1-j)*W +: W] = relu(mode ? cur[j][k] : cur[k][j]);
                exp_q.push_back('{d: w, a: MAW'(BA + tidx * P + k), f: (tidx == NT-1 && k == P-1)});
            end
            tidx     = (tidx + 1) % NT;
            cur_rows = 0;
        end
    endtask

    task automatic monitor();
        wr_t e;
        chk("we_eq_ce", 64'(mem_we_o), 64'(mem_ce_o));
        chk("err_sticky", 64'(err_o), 64'(dropped));
        if (mem_ce_o === 1'b1) begin
            if (!first_seen) begin
                first_seen = 1;
                first_ce   = cyc;
                first_d    = mem_d_o;
            end
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mem_d", 64'(mem_d_o), 64'(e.d));
                chk("mem_addr", 64'(mem_addr_o), 64'(e.a));
                chk("finish", 64'(finish_o), 64'(e.f));
            end
        end else begin
            chk("finish_idle", 64'(finish_o), 64'd0);
        end
    endtask

    // One clock: lane i carries lane i of the row presented i cycles ago.
    task automatic tick(input bit v);
        logic [RW-1:0] r;
        for (int i = 0; i < P; i++) pres[cyc][i] = nrow[i];
        for (int i = 0; i < P; i++)
            r[(P-1-i)*W +: W] = (cyc - i >= 0) ? pres[cyc-i][i] : W'($urandom);
        in_row_i   = r;
        in_valid_i = v;
        #1;
        if (v && in_ready_o) accept_row();
        else if (v) dropped = 1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget exceeded at cycle %0d", cyc);
            $fatal(1);
        end
        monitor();
        for (int i = 0; i < P; i++) nrow[i] = W'($urandom);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        in_valid_i = 1'b0;
        #1;
        chk("rst_ce", 64'(mem_ce_o), 64'd0);
        chk("rst_we", 64'(mem_we_o), 64'd0);
        chk("rst_fin", 64'(finish_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_data", 64'(mem_d_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        exp_q.delete();
        cur_rows = 0;
        tidx     = 0;
        dropped  = 0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
    endtask

    task automatic drain_wait();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(0);
            n++;
        end
        repeat (P + 2) tick(0);
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic directed_tile(input bit m);
        mode = m;
        mode_transpose_i = m;
        first_seen = 0;
        c0 = cyc;
        for (int r = 0; r < P; r++) begin
            for (int i = 0; i < P; i++) nrow[i] = W'(r * 16 + i);
            tick(1);
        end
        drain_wait();
        chk("latency", 64'(first_ce - c0), 64'(2 * P - 1));
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; n_acc = 0;
        cur_rows = 0; tidx = 0; dropped = 0; mode = 0; first_seen = 0;
        for (int i = 0; i < P; i++) nrow[i] = '0;
        @(negedge clk);
        do_reset();

        // Row-major single tile
        directed_tile(1'b0);
        chk("word0_rowmajor", 64'(first_d), 64'h00010203);

        // Transposed single tile
        do_reset();
        directed_tile(1'b1);
        chk("word0_transpose", 64'(first_d), 64'h00102030);

        // Four random tiles, beats offered only while ready; covers wrap and finish
        do_reset();
        mode = 1'($urandom);
        mode_transpose_i = mode;
        n_acc = 0;
        for (int n = 0; n < 400 && n_acc < 4 * P; n++) begin
            if (in_ready_o) tick(1);
            else            tick(0);
        end
        chk("streamed_beats", 64'(n_acc), 64'(4 * P));
        drain_wait();

        // Valid held high regardless of ready: drops must set sticky err
        chk("err_clear_before", 64'(err_o), 64'd0);
        for (int n = 0; n < 60; n++) tick(1);
        drain_wait();
        chk("err_set", 64'(err_o), 64'd1);
        repeat (5) tick(0);
        chk("err_still_set", 64'(err_o), 64'd1);

        // Reset on beat 2 of a tile, then a full tile must restart at the base address
        tick(1);
        tick(1);
        in_valid_i = 1'b1;
        do_reset();
        repeat (10) tick(0);
        first_seen = 0;
        for (int r = 0; r < P; r++) tick(1);
        drain_wait();
        chk("post_rst_addr_seen", 64'(first_seen), 64'd1);

        // Signed extremes through the drain path
        mode = 0;
        mode_transpose_i = 0;
        first_seen = 0;
        for (int r = 0; r < P; r++) begin
            nrow[0] = (r == 0) ? 8'h85 : 8'h80;
            nrow[1] = 8'h7F;
            nrow[2] = 8'h00;
            nrow[3] = W'($urandom);
            tick(1);
        end
        drain_wait();
`ifdef OFMAP_RELU_EN
        chk("relu_neg", 64'(first_d[RW-1 -: W]), 64'h00);
`else
        chk("relu_neg", 64'(first_d[RW-1 -: W]), 64'h85);
`endif
        chk("relu_pos", 64'(first_d[RW-W-1 -: W]), 64'h7F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
